// File: rtl/debug_unit.sv
`timescale 1ns/1ps
// debug_unit: decodes UART command bytes into pipeline clock-enable/reset control and
// streams a frozen snapshot of the pipeline observation words back out. Macro DBG_ECHO_EN echoes commands.
module debug_unit #(
  parameter int         B        = 32,
  parameter int         N_WORDS  = 12,
  parameter logic [7:0] CMD_RUN  = 8'h63,
  parameter logic [7:0] CMD_STEP = 8'h73,
  parameter logic [7:0] CMD_RST  = 8'h72,
  parameter logic [7:0] CMD_DUMP = 8'h64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_done,
  input  logic                 tx_busy,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic [B-1:0]         dbg_pc,
  input  logic                 dbg_halt,
  input  logic [N_WORDS*B-1:0] dbg_words,
  output logic                 pipe_en,
  output logic                 pipe_rst,
  output logic [31:0]          cycle_count,
  output logic [2:0]           state_out
);
  localparam int N_FRAME_WORDS = N_WORDS + 2;
  localparam int FRAME_BYTES   = 4 * N_FRAME_WORDS;
  localparam int IW            = $clog2(FRAME_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    STEP    = 3'd2,
    PRST    = 3'd3,
    SNAP    = 3'd4,
    SEND    = 3'd5,
    WAIT_TX = 3'd6
  } state_t;

  state_t          state_reg, state_next;
  logic            pipe_en_reg, pipe_en_next;
  logic            pipe_rst_reg, pipe_rst_next;
  logic            tx_start_reg, tx_start_next;
  logic [7:0]      tx_data_reg, tx_data_next;
  logic [31:0]     count_reg, count_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic            busy_seen_reg, busy_seen_next;
  logic [B-1:0]    frame_in [N_FRAME_WORDS];
  logic [B-1:0]    snap_reg [N_FRAME_WORDS];
  logic [7:0]      frame_byte;
  logic            rx_is_cmd;
  logic            dispatch;
  logic [7:0]      dispatch_cmd;
  logic            echo_active;
  logic [7:0]      echo_cmd;

  // Frame layout: cycle count, PC, then observation words 0..N_WORDS-1.
  assign frame_in[0] = B'(count_reg);
  assign frame_in[1] = dbg_pc;
  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_words
    assign frame_in[gi+2] = dbg_words[gi*B +: B];
  end

  assign frame_byte = snap_reg[idx_reg[IW-1:2]][{idx_reg[1:0], 3'b000} +: 8];
  assign rx_is_cmd  = rx_data inside {CMD_RUN, CMD_STEP, CMD_RST, CMD_DUMP};

`ifdef DBG_ECHO_EN
  logic       echo_reg, echo_next;
  logic [7:0] cmd_reg, cmd_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_reg <= 1'b0;
      cmd_reg  <= 8'h00;
    end else begin
      echo_reg <= echo_next;
      cmd_reg  <= cmd_next;
    end
  end

  assign echo_active = echo_reg;
  assign echo_cmd    = cmd_reg;
`else
  assign echo_active = 1'b0;
  assign echo_cmd    = 8'h00;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      pipe_en_reg   <= 1'b0;
      pipe_rst_reg  <= 1'b0;
      tx_start_reg  <= 1'b0;
      tx_data_reg   <= 8'h00;
      count_reg     <= 32'd0;
      idx_reg       <= '0;
      busy_seen_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pipe_en_reg   <= pipe_en_next;
      pipe_rst_reg  <= pipe_rst_next;
      tx_start_reg  <= tx_start_next;
      tx_data_reg   <= tx_data_next;
      count_reg     <= count_next;
      idx_reg       <= idx_next;
      busy_seen_reg <= busy_seen_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_FRAME_WORDS; i++) snap_reg[i] <= '0;
    end else if (state_reg == SNAP) begin
      for (int i = 0; i < N_FRAME_WORDS; i++) snap_reg[i] <= frame_in[i];
    end
  end

  always_comb begin
    state_next     = state_reg;
    pipe_en_next   = 1'b0;
    pipe_rst_next  = 1'b0;
    tx_start_next  = 1'b0;
    tx_data_next   = tx_data_reg;
    idx_next       = idx_reg;
    busy_seen_next = busy_seen_reg;
    count_next     = (pipe_en_reg && count_reg != 32'hFFFF_FFFF) ? count_reg + 32'd1 : count_reg;
    dispatch       = 1'b0;
    dispatch_cmd   = rx_data;
`ifdef DBG_ECHO_EN
    echo_next      = echo_reg;
    cmd_next       = cmd_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (rx_done && rx_is_cmd) begin
`ifdef DBG_ECHO_EN
          echo_next  = 1'b1;
          cmd_next   = rx_data;
          state_next = SEND;
`else
          dispatch   = 1'b1;
`endif
        end
      end
      RUN: begin
        // The cycle that samples halt is still enabled and counted.
        if (dbg_halt) state_next = SNAP;
        else          pipe_en_next = 1'b1;
      end
      STEP:    state_next = SNAP;
      PRST:    state_next = IDLE;
      SNAP: begin
        idx_next   = '0;
        state_next = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_data_next   = echo_active ? echo_cmd : frame_byte;
          tx_start_next  = 1'b1;
          busy_seen_next = 1'b0;
          state_next     = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (tx_busy) begin
          busy_seen_next = 1'b1;
        end else if (busy_seen_reg) begin
          if (echo_active) begin
`ifdef DBG_ECHO_EN
            echo_next    = 1'b0;
`endif
            dispatch     = 1'b1;
            dispatch_cmd = echo_cmd;
            state_next   = IDLE;
          end else if (idx_reg == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = SEND;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (dispatch) begin
      case (dispatch_cmd)
        CMD_RUN, CMD_STEP: begin
          if (dbg_halt) begin
            state_next = SNAP;
          end else begin
            state_next   = (dispatch_cmd == CMD_RUN) ? RUN : STEP;
            pipe_en_next = 1'b1;
          end
        end
        CMD_RST: begin
          state_next    = PRST;
          pipe_rst_next = 1'b1;
          count_next    = 32'd0;
        end
        CMD_DUMP: state_next = SNAP;
        default:  state_next = IDLE;
      endcase
    end
  end

  assign tx_data     = tx_data_reg;
  assign tx_start    = tx_start_reg;
  assign pipe_en     = pipe_en_reg;
  assign pipe_rst    = pipe_rst_reg;
  assign cycle_count = count_reg;
  assign state_out   = state_reg;
endmodule

// File: tb/tb_debug_unit.sv
`timescale 1ns/1ps
// tb_debug_unit: directed commands against debug_unit with a UART transmitter responder,
// a running cycle-count model and expected dump frames built from the observed pipeline inputs.
module tb_debug_unit;
  localparam int B     = 32;
  localparam int NW    = 12;
  localparam int FRAME = 4 * (NW + 2);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_done = 1'b0;
  logic          tx_busy = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic [B-1:0]  dbg_pc = '0;
  logic          dbg_halt = 1'b0;
  logic [NW*B-1:0] dbg_words = '0;
  logic          pipe_en;
  logic          pipe_rst;
  logic [31:0]   cycle_count;
  logic [2:0]    state_out;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_count = 32'd0;
  int          n_en = 0;
  int          n_rst = 0;
  int          busy_left = 0;
  int          busy_len = 3;
  logic        prev_start = 1'b0;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] words_val[NW];

  debug_unit dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .dbg_pc(dbg_pc), .dbg_halt(dbg_halt),
    .dbg_words(dbg_words), .pipe_en(pipe_en), .pipe_rst(pipe_rst),
    .cycle_count(cycle_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: sampled on the falling edge; also plays the UART transmitter.
  task automatic tick();
    @(negedge clk);
    if (!reset) model_count = 32'd0;
    if (pipe_rst) begin
      model_count = 32'd0;
      n_rst++;
    end
    chk("cycle_count", cycle_count, model_count);
    if (pipe_en) begin
      n_en++;
      if (model_count != 32'hFFFF_FFFF) model_count = model_count + 32'd1;
    end
    if (state_out == 3'd0) chk("idle_pipe_en", 32'(pipe_en), 32'd0);
    if (tx_start) begin
      chk("tx_start_overlap", 32'(tx_busy | prev_start), 32'd0);
      rx_q.push_back(tx_data);
      busy_left = busy_len;
    end
    prev_start = tx_start;
    if (busy_left > 0) begin
      tx_busy = 1'b1;
      busy_left--;
    end else begin
      tx_busy = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [7:0] c);
    rx_data = c;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic set_inputs(input logic [31:0] pc, input logic [31:0] w0);
    dbg_pc = pc;
    for (int k = 0; k < NW; k++) begin
      words_val[k] = w0 + 32'(k) * 32'h0001_0100;
      dbg_words[k*B +: B] = words_val[k];
    end
  endtask

  task automatic make_exp(input logic [31:0] cnt);
    logic [31:0] w;
    exp_q.delete();
    for (int k = 0; k < NW + 2; k++) begin
      w = (k == 0) ? cnt : (k == 1) ? dbg_pc : words_val[k-2];
      for (int b = 0; b < 4; b++) exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
    end
  endtask

  task automatic wait_frame(input int n, input string name);
    int guard = 0;
    while (!(rx_q.size() >= n && state_out == 3'd0 && !tx_busy) && guard < 20000) begin
      tick();
      guard++;
    end
    chk({name, "_timeout"}, 32'(guard < 20000), 32'd1);
    repeat (10) tick();
    chk({name, "_bytes"}, 32'(rx_q.size()), 32'(n));
  endtask

  task automatic check_frame(input string name);
    int bad = 0;
    for (int i = 0; i < FRAME; i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
    chk({name, "_frame_bad_bytes"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int en0;
    int rst0;
    int starts0;
    int guard;
    int bad;
    logic [7:0] lit[12];

    // Reset state
    set_inputs(32'h0000_0004, 32'hA5A5_0001);
    repeat (3) tick();
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_pipe_en", 32'(pipe_en), 32'd0);
    chk("rst_pipe_rst", 32'(pipe_rst), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_count", cycle_count, 32'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Single step, no halt
    rx_q.delete();
    en0 = n_en;
    send_cmd(8'h73);
    wait_frame(FRAME, "step");
    chk("step_en_cycles", 32'(n_en - en0), 32'd1);
    lit = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hA5, 8'hA5};
    bad = 0;
    for (int i = 0; i < 12; i++) if (rx_q[i] !== lit[i]) bad++;
    chk("step_first12_literal", 32'(bad), 32'd0);
    make_exp(model_count);
    check_frame("step");
    $display("txn step      en=%0d bytes=%0d count=%0d", n_en - en0, rx_q.size(), cycle_count);

    // Pipeline reset before the run so the run frame starts from zero
    rx_q.delete();
    send_cmd(8'h72);
    repeat (10) tick();
    chk("prst0_count", cycle_count, 32'd0);

    // Continuous run, halt raised during the 10th enabled cycle
    set_inputs(32'h0000_0040, 32'h1111_2222);
    rx_q.delete();
    en0 = n_en;
    send_cmd(8'h63);
    guard = 0;
    while (n_en - en0 < 10 && guard < 200) begin
      tick();
      guard++;
    end
    dbg_halt = 1'b1;
    wait_frame(FRAME, "run");
    chk("run_en_cycles", 32'(n_en - en0), 32'd10);
    chk("run_first4_literal", {rx_q[3], rx_q[2], rx_q[1], rx_q[0]}, 32'h0000_000A);
    chk("run_state_idle", 32'(state_out), 32'd0);
    make_exp(model_count);
    check_frame("run");
    $display("txn run       en=%0d bytes=%0d count=%0d", n_en - en0, rx_q.size(), cycle_count);

    // Step while already halted: no enable, count unchanged
    rx_q.delete();
    en0 = n_en;
    send_cmd(8'h73);
    wait_frame(FRAME, "step_halted");
    chk("step_halted_en", 32'(n_en - en0), 32'd0);
    chk("step_halted_first4", {rx_q[3], rx_q[2], rx_q[1], rx_q[0]}, 32'h0000_000A);
    make_exp(model_count);
    check_frame("step_halted");
    $display("txn step_halt en=%0d bytes=%0d count=%0d", n_en - en0, rx_q.size(), cycle_count);

    // Pipeline reset: one pulse, count cleared, nothing transmitted
    rx_q.delete();
    rst0 = n_rst;
    send_cmd(8'h72);
    repeat (20) tick();
    chk("prst_pulses", 32'(n_rst - rst0), 32'd1);
    chk("prst_count", cycle_count, 32'd0);
    chk("prst_tx_bytes", 32'(rx_q.size()), 32'd0);
    $display("txn reset     pulses=%0d bytes=%0d count=%0d", n_rst - rst0, rx_q.size(), cycle_count);

    // Dump after reset
    send_cmd(8'h64);
    wait_frame(FRAME, "dump0");
    chk("dump0_first4", {rx_q[3], rx_q[2], rx_q[1], rx_q[0]}, 32'h0000_0000);
    make_exp(32'd0);
    check_frame("dump0");
    $display("txn dump      bytes=%0d count=%0d", rx_q.size(), cycle_count);

    // Unknown byte is ignored
    rx_q.delete();
    en0 = n_en;
    send_cmd(8'h78);
    repeat (20) tick();
    chk("bad_cmd_bytes", 32'(rx_q.size()), 32'd0);
    chk("bad_cmd_state", 32'(state_out), 32'd0);
    chk("bad_cmd_en", 32'(n_en - en0), 32'd0);
    $display("txn ignored   bytes=%0d", rx_q.size());

    // Slow transmitter, command and input changes injected mid-frame
    busy_len = 20;
    set_inputs(32'h1234_5678, 32'hCAFE_0000);
    make_exp(model_count);
    rx_q.delete();
    en0 = n_en;
    send_cmd(8'h64);
    guard = 0;
    while (rx_q.size() < 3 && guard < 2000) begin
      tick();
      guard++;
    end
    dbg_halt = 1'b0;
    send_cmd(8'h63);
    set_inputs(32'hDEAD_BEEF, 32'h5555_AAAA);
    wait_frame(FRAME, "busy");
    chk("busy_dropped_cmd_en", 32'(n_en - en0), 32'd0);
    check_frame("busy");
    $display("txn slow_dump en=%0d bytes=%0d", n_en - en0, rx_q.size());

    // Reset asserted mid-frame
    busy_len = 3;
    rx_q.delete();
    send_cmd(8'h64);
    guard = 0;
    while (rx_q.size() < 7 && guard < 2000) begin
      tick();
      guard++;
    end
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    chk("midrst_state", 32'(state_out), 32'd0);
    chk("midrst_pipe_en", 32'(pipe_en), 32'd0);
    chk("midrst_count", cycle_count, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    starts0 = rx_q.size();
    repeat (40) tick();
    chk("midrst_no_resume", 32'(rx_q.size()), 32'(starts0));
    $display("txn abort     bytes_before_reset=%0d", starts0);

    rx_q.delete();
    make_exp(32'd0);
    send_cmd(8'h64);
    wait_frame(FRAME, "after_rst");
    check_frame("after_rst");
    $display("txn dump      bytes=%0d count=%0d", rx_q.size(), cycle_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
